// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the uart block family
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT
  } arb_state_t;

  localparam int DEFAULT_LOCK_TIMEOUT = 1024;

  typedef logic [7:0] uart_byte_t;

  // Successor of idx in a ring of n entries.
  function automatic int ring_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority selector starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  // Scan from the farthest offset down so the entry closest to ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        sel = W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locking arbiter in front of uart_tx
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 start_send,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             lock;
  logic             last_q;
  logic [CNT_W-1:0] lock_cnt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick_sel;
  logic             pick_any;
  logic [ID_W-1:0]  sel;
  logic             sel_any;
  logic             accept;
  logic             lock_hit;
  logic             lock_idle;
  logic [ID_W-1:0]  next_ptr;

  rr_pick #(
    .N(NUM_REQ),
    .W(ID_W)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .sel(pick_sel),
    .any(pick_any)
  );

  // A locked channel only ever serves its current owner.
  always_comb begin
    if (lock) begin
      sel     = grant_id;
      sel_any = req_valid[grant_id];
    end else begin
      sel     = pick_sel;
      sel_any = pick_any;
    end
  end

  assign accept    = (state == ARB_IDLE) && sel_any;
  assign lock_hit  = (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));
  assign lock_idle = (state == ARB_IDLE) && lock && !req_valid[grant_id];
  assign next_ptr  = ID_W'(ring_next(int'(grant_id), NUM_REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (sel_any) state_nxt = ARB_START;
      ARB_START: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (tx_done) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    start_send = (state == ARB_START);
    busy       = (state == ARB_START) || (state == ARB_WAIT);
    req_ready  = '0;
    if (accept) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte  <= '0;
      grant_id <= '0;
      last_q   <= 1'b0;
      lock     <= 1'b0;
      lock_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        tx_byte  <= req_byte[8*sel +: 8];
        grant_id <= sel;
        last_q   <= req_last[sel];
        lock_cnt <= '0;
      end else if (lock_idle) begin
        // Owner went quiet mid-message; give the channel back after the timeout.
        if (lock_hit) begin
          lock   <= 1'b0;
          rr_ptr <= next_ptr;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end

      if ((state == ARB_WAIT) && tx_done) begin
        if (last_q) begin
          lock   <= 1'b0;
          rr_ptr <= next_ptr;
        end else begin
          lock     <= 1'b1;
          lock_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx instance between NUM_REQ byte producers, e.g. the rx echo path, a status reporter and a debug dumper.
- Accepts bytes over per-requester valid/ready handshakes and picks a requester round-robin.
- Issues one start_send pulse per byte and waits for the transmitter's done pulse before accepting the next byte.
- Supports multi-byte messages: a requester keeps the channel until it marks its final byte with req_last, so messages are never interleaved.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- LOCK_TIMEOUT, 1024, clock cycles a locked requester may stay idle before the lock is forcibly released.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i holds a byte.
- req_byte  in  NUM_REQ*8  byte of requester i, located at [8*i+7:8*i].
- req_last  in  NUM_REQ  marks the offered byte as the last byte of its message.
- req_ready  out  NUM_REQ  byte accepted from requester i in this cycle.
- tx_byte  out  8  byte presented to uart_tx.tx_byte.
- start_send  out  1  one-cycle pulse to uart_tx.start_send.
- tx_done  in  1  one-cycle pulse from uart_tx.done at the end of the stop bit.
- grant_id  out  ID_W  index of the requester currently or most recently served.
- busy  out  1  high while a byte is being transmitted, i.e. in states START and WAIT.

Behaviour:
- Reset state: IDLE. tx_byte=0, start_send=0, grant_id=0, busy=0, req_ready=0, rr_ptr=0, lock=0, lock_cnt=0.
- Reset may assert mid-byte. The arbiter then returns to IDLE immediately and does not track the byte already handed to uart_tx. uart_tx shares the same reset, so it aborts too.
- Selection in IDLE:
  - Unlocked: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Locked: only grant_id is eligible.
- Acceptance in IDLE:
  - req_ready[sel]=1 for one cycle, combinational from state, lock, rr_ptr and req_valid.
  - At most one ready bit is high, and never while req_valid is low.
  - On the same clock edge: tx_byte<=req_byte[sel], grant_id<=sel, last_q<=req_last[sel], go to START.
- START, one cycle: start_send=1, busy=1, tx_byte held. Go to WAIT. A tx_done arriving in START is ignored.
- WAIT: busy=1, tx_byte held stable, start_send=0. On tx_done go to IDLE with:
  - If last_q=1: lock<=0, rr_ptr<=(grant_id+1) mod NUM_REQ.
  - If last_q=0: lock<=1, lock_cnt<=0, rr_ptr unchanged.
- Throughput: accept edge, then START cycle, then WAIT until done. The earliest next accept is the cycle after tx_done.
- Lock timeout:
  - While lock=1 in IDLE and req_valid[grant_id]=0, lock_cnt increments each cycle.
  - When lock_cnt reaches LOCK_TIMEOUT-1: lock<=0, rr_ptr<=(grant_id+1) mod NUM_REQ. The next cycle selects unlocked.
  - lock_cnt saturates and clears on every accept.
- Simultaneous requests: exactly one is served. The losers keep valid high, and their data must stay stable until ready.
- All requesters idle: the arbiter stays in IDLE, outputs stay stable, rr_ptr is unchanged.
- rr_ptr wrap: when grant_id=NUM_REQ-1, the next rr_ptr is 0.
- grant_id and tx_byte are registered; start_send and busy decode from the state register. No combinational path from tx_done to any output.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_START, ARB_WAIT} arb_state_t;
  - localparam default LOCK_TIMEOUT;
  - typedef logic [7:0] uart_byte_t, shared with uart_tx/uart_rx.
- One sub-module is natural: rr_pick, a purely combinational rotate-priority selector (inputs req, ptr; outputs sel and any). It is reusable for future arbiters.

Test Plan:
- Single byte: req_valid[2]=1, byte 0x41, last=1 → req_ready[2] pulses once. start_send pulses exactly one cycle later with tx_byte=0x41 and grant_id=2. busy stays high until the injected tx_done; the next rr_ptr is 3.
- Fairness: all four requesters hold valid with last=1 and bytes 0xA0..0xA3, rr_ptr=0 → transmit order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0. No requester is skipped or repeated.
- Message lock: req 1 sends 0x10 (last=0), 0x11 (last=0), 0x12 (last=1) while req 0 and req 3 stay valid → 0x10, 0x11, 0x12 go out contiguously. Req 3 is served next, not req 0.
- Lock timeout: LOCK_TIMEOUT=16; req 0 sends a byte with last=0, then drops valid while req 2 is valid → exactly 16 idle cycles after tx_done, req 2 is accepted and grant_id=2.
- Done timing: tx_done asserted during START is ignored, so the arbiter stays in WAIT until the second tx_done. tx_byte is stable throughout WAIT.
- Reset mid-operation: assert rst asynchronously in WAIT → start_send, busy, req_ready and tx_byte drop to 0 immediately. After release, the first valid request is accepted from rr_ptr=0.
